// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues ALU ops from a small register file and collects the results.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds valid (and its payload) until that
// edge. instr_ready is a pure decode of the IDLE state. res_valid, res_data and
// res_rd stay stable until the edge where res_ready is 1.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int REGS  = 4,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_ld,
    input  logic [1:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] src_a,
    output logic [WIDTH-1:0] src_b,
    output logic [1:0]       ALU_Control,
    input  logic [WIDTH-1:0] ALU_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_rd,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rf_q [REGS];
    logic [WIDTH-1:0] src_a_q;
    logic [WIDTH-1:0] src_b_q;
    logic [1:0]       ctrl_q;
    logic [AW-1:0]    rd_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [AW-1:0]    res_rd_q;

    // Sequencer FSM, register file and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < REGS; i++) begin
                rf_q[i] <= '0;
            end
            src_a_q     <= '0;
            src_b_q     <= '0;
            ctrl_q      <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        if (instr_ld) begin
                            // Load immediate completes in place; no response is produced.
                            rf_q[instr_rd] <= instr_imm;
                        end else begin
                            // Operands are captured now, so rd may alias rs1/rs2 safely.
                            src_a_q <= rf_q[instr_rs1];
                            src_b_q <= rf_q[instr_rs2];
                            ctrl_q  <= instr_op;
                            rd_q    <= instr_rd;
                            state_q <= OPER;
                        end
                    end
                end
                OPER: begin
                    // ALU inputs have been stable for a full cycle; capture the result.
                    res_data_q  <= ALU_out;
                    rf_q[rd_q]  <= ALU_out;
                    res_rd_q    <= rd_q;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode: ready only in IDLE, everything else straight from registers.
    always_comb begin
        instr_ready = (state_q == IDLE);
        src_a       = src_a_q;
        src_b       = src_b_q;
        ALU_Control = ctrl_q;
        res_valid   = res_valid_q;
        res_data    = res_data_q;
        res_rd      = res_rd_q;
        dbg_state_o = state_q;
    end

endmodule
